// File: rtl/serial_to_parallel_rx_if.sv
// Byte-side bus of the receive deserializer: serial bit in, aligned byte out.
// byte_strobe qualifies data_out/valid_out for one cycle; there is no back-pressure.
interface serial_to_parallel_rx_if #(
  parameter int WIDTH = 8
);
  logic             data_in;
  logic [WIDTH-1:0] data_out;
  logic             valid_out;
  logic             byte_strobe;
  logic             active;

  modport master (
    output data_in,
    input  data_out,
    input  valid_out,
    input  byte_strobe,
    input  active
  );

  modport slave (
    input  data_in,
    output data_out,
    output valid_out,
    output byte_strobe,
    output active
  );
endinterface

// File: rtl/serial_to_parallel_rx.sv
// Serial-to-parallel receiver: finds byte alignment on COM symbols, locks after
// LOCK_COUNT aligned COMs, then delivers one byte every WIDTH bit clocks.
module serial_to_parallel_rx #(
  parameter int               WIDTH      = 8,
  parameter logic [WIDTH-1:0] COM_SYMBOL = 8'hBC,
  parameter int               LOCK_COUNT = 4
) (
  input  logic                 clk_32f,
  input  logic                 reset,
  serial_to_parallel_rx_if.slave rx,
  output logic [1:0]           state_dbg
);

  localparam int CW = $clog2(WIDTH);
  localparam int LW = $clog2(LOCK_COUNT + 1);

  localparam logic [1:0] SEARCH   = 2'd0;
  localparam logic [1:0] ALIGNING = 2'd1;
  localparam logic [1:0] ACTIVE   = 2'd2;

  localparam logic [CW-1:0] LAST_BIT  = CW'(WIDTH - 1);
  localparam logic [LW-1:0] LOCK_LAST = LW'(LOCK_COUNT - 1);
  localparam logic [LW-1:0] LOCK_FULL = LW'(LOCK_COUNT);

  logic [WIDTH-1:0] sr;
  logic [CW-1:0]    bit_cnt;
  logic [LW-1:0]    com_cnt;
  logic [1:0]       state;
  logic [WIDTH-1:0] data_q;
  logic             valid_q;
  logic             strobe_q;
  logic             active_q;

  logic is_com;
  logic boundary;

  assign is_com   = (sr == COM_SYMBOL);
  // bit_cnt is reloaded to 0 on the edge after a boundary, so the next
  // boundary falls exactly WIDTH cycles later when it reaches its last value.
  assign boundary = (bit_cnt == LAST_BIT);

  always_ff @(posedge clk_32f or posedge reset) begin
    if (reset) begin
      sr       <= '0;
      bit_cnt  <= '0;
      com_cnt  <= '0;
      state    <= SEARCH;
      data_q   <= '0;
      valid_q  <= 1'b0;
      strobe_q <= 1'b0;
      active_q <= 1'b0;
    end else begin
      sr       <= {sr[WIDTH-2:0], rx.data_in};
      strobe_q <= 1'b0;
      case (state)
        SEARCH: begin
          if (is_com) begin
            state   <= ALIGNING;
            com_cnt <= LW'(1);
            bit_cnt <= '0;
          end
        end
        ALIGNING: begin
          bit_cnt <= bit_cnt + 1'b1;
          if (boundary) begin
            if (!is_com) begin
              state   <= SEARCH;
              com_cnt <= '0;
            end else if (com_cnt == LOCK_LAST) begin
              // The lock-completing COM is registered like any idle byte.
              state    <= ACTIVE;
              com_cnt  <= LOCK_FULL;
              active_q <= 1'b1;
              data_q   <= sr;
              valid_q  <= 1'b0;
              strobe_q <= 1'b1;
            end else begin
              com_cnt <= com_cnt + 1'b1;
            end
          end
        end
        ACTIVE: begin
          bit_cnt <= bit_cnt + 1'b1;
          if (boundary) begin
            data_q   <= sr;
            valid_q  <= !is_com;
            strobe_q <= 1'b1;
          end
        end
        default: begin
          state   <= SEARCH;
          com_cnt <= '0;
          bit_cnt <= '0;
        end
      endcase
    end
  end

  assign rx.data_out    = data_q;
  assign rx.valid_out   = valid_q;
  assign rx.byte_strobe = strobe_q;
  assign rx.active      = active_q;
  assign state_dbg      = state;

endmodule

// File: doc/serial_to_parallel_rx.md
Name: serial_to_parallel_rx

Overview:
- Receive-side deserializer of the PHY. It consumes the single-bit serial stream on the clk_32f domain and finds byte alignment using the COM symbol 8'hBC.
- It declares the link active after a run of consecutive aligned COM symbols.
- From then on it delivers one byte per 8 clk_32f cycles, i.e. one per clk_4f period, to the downstream byte-striping/demux stage.
- COM bytes seen while active are idle fill and are flagged invalid.

Parameters:
- WIDTH, 8, parallel word width; bits per symbol.
- COM_SYMBOL, 8'hBC, alignment/idle symbol.
- LOCK_COUNT, 4, consecutive aligned COM symbols required to assert active.

Ports:
- clk_32f  input  1  serial bit clock; all state changes on rising edge.
- reset  input  1  asynchronous, active-high reset.
- data_in  input  1  serial bit, MSB of each symbol first.
- data_out  output  WIDTH  last aligned byte.
- valid_out  output  1  data_out is payload (not COM) and link is active.
- byte_strobe  output  1  one-cycle pulse when data_out/valid_out update.
- active  output  1  alignment locked.

Behaviour:
- Shift register, every rising edge: sr <= {sr[WIDTH-2:0], data_in}.
- Reset (asynchronous, any time, including mid-byte):
  - sr, bit counter, COM counter and state clear to 0/SEARCH.
  - data_out=0, valid_out=0, byte_strobe=0, active=0.
  - After reset deasserts, the block starts again from SEARCH with no memory of prior alignment.
- States:
  - SEARCH:
    - Sliding compare each cycle.
    - The first cycle with sr==COM_SYMBOL is a boundary cycle. Go to ALIGNING, com_cnt=1, bit counter=0.
    - No outputs change.
  - ALIGNING:
    - Bit counter runs 0..WIDTH-1 and wraps; every WIDTH cycles after the previous boundary is a boundary cycle.
    - At a boundary with sr==COM: com_cnt+1. When com_cnt reaches LOCK_COUNT, go to ACTIVE.
    - At a boundary with sr!=COM: go to SEARCH, com_cnt=0.
    - COM patterns at non-boundary offsets are ignored.
  - ACTIVE:
    - At each boundary, data_out<=sr and valid_out<=(sr!=COM_SYMBOL).
    - Stays ACTIVE until reset; there is no loss-of-lock exit.
- Output timing, all registered:
  - Outputs update on the rising edge following a boundary cycle, and byte_strobe=1 for exactly that one cycle.
  - data_out/valid_out then hold for WIDTH cycles.
  - Latency: the last bit of a byte is sampled at edge N; data_out shows it after edge N+1.
- active:
  - Set on the same edge that would register the LOCK_COUNT-th COM. That COM gives valid_out=0 and byte_strobe=1.
  - Before active, byte_strobe, valid_out and data_out stay 0.
- Lock corner: a boundary COM that completes the lock count and a non-COM at the next boundary are independent. The non-COM is delivered with valid_out=1.
- The bit counter must use $clog2(WIDTH) bits and wrap without an explicit compare-to-WIDTH error.

Test Plan:
- Lock then data: reset 2 cycles; send BC,BC,BC,BC,A5,3C MSB-first.
  - active rises one cycle after the 4th BC's last bit.
  - data_out=A5/valid=1, then 3C/valid=1, each 8 cycles apart with a byte_strobe pulse.
- Misaligned start: 3 junk bits 1,1,0, then 4×BC, then 5A.
  - Locks on the true boundary; data_out=5A, valid_out=1.
- Broken lock: BC,BC,BC,77,BC,BC,BC,BC,E1.
  - active stays 0 through 77 (returns to SEARCH).
  - After the second BC run: active=1, data_out=E1, valid=1.
- Idle while active: after lock send 12,BC,34.
  - Sequence is 12/valid1, BC/valid0, 34/valid1.
  - byte_strobe pulses 3 times; active stays 1.
- Reset mid-operation: assert reset between clock edges mid-byte while active.
  - All outputs go 0 immediately, without waiting for a clock edge.
  - After release, 4×BC plus 99 relocks with data_out=99.
- False COM across boundary: after alignment, bytes 0B,C0 (embedded BC spanning the boundary) during ALIGNING.
  - Boundary sees 0B, so state returns to SEARCH; the embedded pattern is ignored as a boundary match.
